// File: rtl/delay_meter_multi.sv
// Multi-channel delay meter. It launches one edge into N_CH external delay paths
// and timestamps the synchronised return of each path, with a timeout.
module delay_meter_multi #(
    parameter int              CNT_W   = 32,
    parameter int              N_CH    = 4,
    parameter int              SETTLE  = 16,
    parameter int              MAX_CYC = 1000,
    parameter logic [N_CH-1:0] RET_INV = {N_CH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cnt_en,
    input  logic [N_CH-1:0]       path_return,
    output logic                  path_launch,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [N_CH-1:0]       arrived,
    output logic [N_CH*CNT_W-1:0] stamp,
    output logic [CNT_W-1:0]      free_cnt
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LAUNCH,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [SET_W-1:0]   r_settleCnt;
    logic [CNT_W-1:0]   r_measCnt;
    logic [CNT_W-1:0]   r_freeCnt;
    logic [N_CH-1:0]    r_sync1;
    logic [N_CH-1:0]    r_sync2;
    logic               r_launch;
    logic               r_timeout;
    logic [N_CH-1:0]    r_arrived;
    logic [CNT_W-1:0]   r_stamp [N_CH];

    logic [N_CH-1:0]    w_retS;
    logic [N_CH-1:0]    w_hit;
    logic               w_allArr;
    logic               w_measEnd;
    logic               w_settleEnd;

    // In MEASURE the launch register already holds the new level, so it is the target.
    assign w_retS      = r_sync2 ^ RET_INV;
    assign w_hit       = ~r_arrived & ~(w_retS ^ {N_CH{r_launch}});
    assign w_allArr    = &(r_arrived | w_hit);
    assign w_measEnd   = (r_measCnt == CNT_W'(MAX_CYC - 1));
    assign w_settleEnd = (r_settleCnt == SET_W'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (start) w_nextState = S_ARM;
            S_ARM:     if (w_settleEnd) w_nextState = S_LAUNCH;
            S_LAUNCH:  w_nextState = S_MEASURE;
            S_MEASURE: if (w_allArr || w_measEnd) w_nextState = S_DONE;
            S_DONE:    w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= path_return;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_freeCnt <= '0;
        end else if (cnt_en) begin
            r_freeCnt <= r_freeCnt + 1'b1;
        end
    end

    // A final arrival on the timeout cycle wins: timeout is only flagged if something is still missing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settleCnt <= '0;
            r_measCnt   <= '0;
            r_launch    <= 1'b0;
            r_timeout   <= 1'b0;
            r_arrived   <= '0;
            for (int i = 0; i < N_CH; i++) r_stamp[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_arrived   <= '0;
                        r_timeout   <= 1'b0;
                        r_settleCnt <= '0;
                        for (int i = 0; i < N_CH; i++) r_stamp[i] <= '0;
                    end
                end
                S_ARM: begin
                    r_settleCnt <= r_settleCnt + 1'b1;
                end
                S_LAUNCH: begin
                    r_launch  <= ~r_launch;
                    r_measCnt <= '0;
                end
                S_MEASURE: begin
                    r_measCnt <= r_measCnt + 1'b1;
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_hit[i]) begin
                            r_arrived[i] <= 1'b1;
                            r_stamp[i]   <= r_measCnt;
                        end else if (!r_arrived[i] && w_measEnd) begin
                            r_stamp[i]   <= '1;
                        end
                    end
                    if (!w_allArr && w_measEnd) r_timeout <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_stamp
        assign stamp[g*CNT_W +: CNT_W] = r_stamp[g];
    end

    assign path_launch = r_launch;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign timeout     = r_timeout;
    assign arrived     = r_arrived;
    assign free_cnt    = r_freeCnt;

endmodule

// File: tb/tb_delay_meter_multi.sv
// Bench for delay_meter_multi: models each delay path as a launch history tap and
// scoreboards the expected arrival pattern of every measurement.
module tb_delay_meter_multi;

    localparam int         CNT_W   = 8;
    localparam int         N_CH    = 4;
    localparam int         SETTLE  = 4;
    localparam int         MAX_CYC = 20;
    localparam logic [3:0] INV     = 4'b0010;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  cnt_en = 1'b0;
    logic [N_CH-1:0]       path_return;
    logic                  path_launch;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic [N_CH-1:0]       arrived;
    logic [N_CH*CNT_W-1:0] stamp;
    logic [CNT_W-1:0]      free_cnt;

    typedef struct {
        logic [3:0]  arr;
        logic        to;
        logic        lvl;
        logic [31:0] st;
        int          doneCyc;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        lastExp;
    int          nCmp = 0;
    int          nFail = 0;
    int          cyc = 0;
    int          delayCh[4] = '{0, 0, 0, 0};
    logic [3:0]  stuckMask = 4'b0000;
    logic        frozenLvl = 1'b0;
    logic        expLvl = 1'b0;
    logic [63:0] hist = '0;
    logic [7:0]  freeExp = '0;
    bit          randCnt = 1'b0;

    delay_meter_multi #(
        .CNT_W(CNT_W), .N_CH(N_CH), .SETTLE(SETTLE), .MAX_CYC(MAX_CYC), .RET_INV(INV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cnt_en(cnt_en),
        .path_return(path_return), .path_launch(path_launch), .busy(busy),
        .done(done), .timeout(timeout), .arrived(arrived), .stamp(stamp),
        .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hist <= {hist[62:0], path_launch};
        if (rst) freeExp <= '0;
        else if (cnt_en) freeExp <= freeExp + 8'd1;
    end

    // Path i is the launch level delayed by delayCh[i] cycles, optionally stuck, optionally inverted.
    always_comb begin
        path_return = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (stuckMask[i]) path_return[i] = frozenLvl ^ INV[i];
            else if (delayCh[i] == 0) path_return[i] = path_launch ^ INV[i];
            else path_return[i] = hist[delayCh[i]-1] ^ INV[i];
        end
    end

    always @(negedge clk) begin
        if (randCnt) cnt_en = 1'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
                checkOutput("arrived", 32'(arrived), 32'(e.arr));
                checkOutput("timeout", 32'(timeout), 32'(e.to));
                checkOutput("launch_level", 32'(path_launch), 32'(e.lvl));
                for (int i = 0; i < N_CH; i++)
                    checkOutput($sformatf("stamp%0d", i), 32'(stamp[i*CNT_W +: CNT_W]), 32'(e.st[i*8 +: 8]));
                checkOutput("free_cnt_at_done", 32'(free_cnt), 32'(freeExp));
            end
        end
    end

    // Expected result from the path delays alone: arrival at delay+2 unless it misses the window.
    function automatic exp_t modelRun(input int s);
        exp_t e;
        int   endM = 0;
        bit   allA = 1'b1;
        e.lvl = ~expLvl;
        e.arr = '0;
        e.st  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (stuckMask[i] || (delayCh[i] + 2 > MAX_CYC - 1)) begin
                e.st[i*8 +: 8] = 8'hFF;
                allA = 1'b0;
            end else begin
                e.arr[i] = 1'b1;
                e.st[i*8 +: 8] = 8'(delayCh[i] + 2);
                if (delayCh[i] + 2 > endM) endM = delayCh[i] + 2;
            end
        end
        if (!allA) endM = MAX_CYC - 1;
        e.to = !allA;
        e.doneCyc = s + SETTLE + endM + 2;
        return e;
    endfunction

    task automatic applyStimulus(input int d0, input int d1, input int d2, input int d3,
                                 input logic [3:0] stk, input bit poke);
        int k;
        @(negedge clk);
        delayCh[0] = d0; delayCh[1] = d1; delayCh[2] = d2; delayCh[3] = d3;
        stuckMask = stk;
        frozenLvl = expLvl;
        lastExp = modelRun(cyc + 1);
        sbQ.push_back(lastExp);
        expLvl = ~expLvl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        if (poke) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) checkOutput("run_cycle_bound", 32'(busy), 32'd0);
        repeat (25) @(negedge clk);
        checkOutput("arrived_hold", 32'(arrived), 32'(lastExp.arr));
        checkOutput("stamp_hold", 32'(stamp), lastExp.st);
        stuckMask = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_launch", 32'(path_launch), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_arrived", 32'(arrived), 32'd0);
        checkOutput("rst_stamp", 32'(stamp), 32'd0);
        checkOutput("rst_free_cnt", 32'(free_cnt), 32'd0);

        cnt_en = 1'b1;
        repeat (5) @(negedge clk);
        cnt_en = 1'b0;
        checkOutput("free_cnt_5", 32'(free_cnt), 32'd5);
        repeat (3) @(negedge clk);
        checkOutput("free_cnt_hold", 32'(free_cnt), 32'd5);
        cnt_en = 1'b1;
        repeat (250) @(negedge clk);
        checkOutput("free_cnt_max", 32'(free_cnt), 32'd255);
        @(negedge clk);
        cnt_en = 1'b0;
        checkOutput("free_cnt_wrap", 32'(free_cnt), 32'd0);

        applyStimulus(0, 0, 0, 0, 4'b0000, 1'b0);
        applyStimulus(0, 3, 6, 9, 4'b0000, 1'b0);
        applyStimulus(0, 3, 6, 9, 4'b0000, 1'b0);
        applyStimulus(0, 3, 6, 9, 4'b0100, 1'b0);
        applyStimulus(1, 17, 2, 5, 4'b0000, 1'b0);
        applyStimulus(1, 18, 2, 5, 4'b0000, 1'b0);
        applyStimulus(4, 4, 4, 4, 4'b0000, 1'b1);

        @(negedge clk);
        stuckMask = 4'b1111;
        frozenLvl = expLvl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expLvl = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_launch", 32'(path_launch), 32'd0);
        checkOutput("abort_stamp", 32'(stamp), 32'd0);
        checkOutput("abort_arrived", 32'(arrived), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (25) @(negedge clk);
        stuckMask = '0;
        repeat (25) @(negedge clk);
        applyStimulus(2, 7, 0, 11, 4'b0000, 1'b0);

        randCnt = 1'b1;
        for (int r = 0; r < 30; r++) begin
            logic [3:0] stk;
            for (int i = 0; i < N_CH; i++) stk[i] = ($urandom_range(0, 7) == 0);
            applyStimulus($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                          $urandom_range(0, 20), stk, 1'($urandom_range(0, 1)));
        end
        randCnt = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/delay_meter_multi.md
Name: delay_meter_multi

Overview:
- Parametrised successor to the single-path delay datapath.
- Drives one launch edge into up to N_CH external delay paths (singlepath/spypath/not-chain instances sit outside this block).
- Synchronises each path return and timestamps its arrival in clock cycles, with timeout.
- Keeps the free-running enabled cycle counter as a separate output.

Parameters:
- CNT_W, 32, width of the free-running counter and of each timestamp.
- N_CH, 4, number of delay-path channels measured in parallel.
- SETTLE, 16, ARM-state cycles allowed for the paths to settle before launch (>=1).
- MAX_CYC, 1000, measurement timeout in cycles (2 < MAX_CYC < 2^CNT_W).
- RET_INV, {N_CH{1'b0}}, per-channel mask; bit set = that path inverts, so its return is XORed before compare.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a measurement; sampled only in IDLE
- cnt_en  in  1  free-running counter increment enable
- path_return  in  N_CH  raw (asynchronous) outputs of the delay paths
- path_launch  out  1  registered launch level driven into all paths
- busy  out  1  high in ARM, LAUNCH, MEASURE, DONE
- done  out  1  one-cycle pulse at measurement end
- timeout  out  1  high if the last measurement ended by timeout; held until next start
- arrived  out  N_CH  per-channel arrival flags of last measurement
- stamp  out  N_CH*CNT_W  per-channel arrival cycle count; channel i at bits [i*CNT_W +: CNT_W]
- free_cnt  out  CNT_W  free-running counter

Behaviour:
- Reset (rst=1 at a clk edge) clears all of the following to 0:
  - state (to IDLE), path_launch, busy, done, timeout, arrived, all stamps
  - free_cnt, the measurement counter meas_cnt, and both synchroniser stages
- Reset mid-measurement aborts the run. path_launch returns to 0 and no done pulse is produced.
- free_cnt: +1 per cycle when cnt_en=1, otherwise holds. Wraps from 2^CNT_W-1 to 0. Independent of the FSM.
- Synchroniser: two flops per channel on path_return. ret_s = sync2 XOR RET_INV.
- FSM states: IDLE, ARM, LAUNCH, MEASURE, DONE.
- IDLE:
  - start=1 -> ARM.
  - Same edge: clear arrived, timeout, stamps; load settle counter with 0.
- ARM:
  - Counts SETTLE cycles, then -> LAUNCH.
  - Paths are not checked for settling; SETTLE must cover the worst path.
- LAUNCH (exactly 1 cycle):
  - At its closing edge path_launch toggles, meas_cnt <= 0, state -> MEASURE.
  - target = new path_launch value.
- MEASURE:
  - meas_cnt increments each cycle.
  - For each channel with arrived[i]=0 and ret_s[i]==target in a cycle: at that cycle's edge, arrived[i]<=1 and stamp[i]<=current meas_cnt.
  - Latency: stamps include the 2-cycle synchroniser delay and are not compensated. A zero-delay path yields stamp=2.
  - First arrival only: a later glitch on an arrived channel is ignored.
  - Multiple channels arriving in the same cycle are all captured with the same stamp.
  - All arrived bits set (including the final bit set at this edge) -> DONE.
  - Else if meas_cnt == MAX_CYC-1 -> DONE with timeout<=1; stamps of non-arrived channels <= all ones.
  - Simultaneous last arrival and timeout in the same cycle: the arrival is recorded and timeout stays 0.
- DONE (1 cycle): done=1, then -> IDLE. path_launch keeps its level, so the next run launches the opposite edge.
- start while busy=1 is ignored; it is not queued.
- Outputs hold their values in IDLE until the next accepted start.

Test Plan:
- Reset then idle, cnt_en=1 for 5 cycles -> free_cnt=5. cnt_en=0 -> free_cnt holds. Preload near wrap: 2^CNT_W-1 -> 0.
- SETTLE=4, returns tied combinationally to path_launch, start pulse -> busy next cycle; path_launch toggles 0->1 after 5 busy cycles; all stamps=2, all arrived=1, done pulses one cycle, timeout=0.
- Channel i delayed by i*3 cycles (bench model) -> stamp[i]=2+3i. Second run launches falling edge with identical stamps.
- Channel 2 tied 0, MAX_CYC=20 -> done at meas_cnt 19, timeout=1, arrived=4'b1011, stamp[2]=all ones, others valid.
- RET_INV bit 1 set with an inverting model on channel 1 -> channel 1 stamp matches non-inverting channels. start asserted in MEASURE -> no effect.
- rst during MEASURE -> next cycle state IDLE, path_launch=0, stamps=0, no done pulse. A new start after that completes normally.
